// File: rtl/ahb_apb_bridge_pkg.sv
// Shared AHB-Lite / APB4 types and constants for the peripheral-port AHB-to-APB bridge.
package ahb_apb_bridge_pkg;

  localparam int AHB_ADDR_W = 32;
  localparam int AHB_DATA_W = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef struct packed {
    logic [AHB_ADDR_W-1:0] haddr;
    logic [AHB_DATA_W-1:0] hwdata;
    logic [1:0]            htrans;
    logic [2:0]            hburst;
    logic [2:0]            hsize;
    logic                  hwrite;
    logic [3:0]            hprot;
    logic                  hmastlock;
  } mas_send_type;

  typedef struct packed {
    logic                  hreadyout;
    logic [AHB_DATA_W-1:0] hrdata;
    logic                  hresp;
  } slv_send_type;

  typedef struct packed {
    logic [AHB_ADDR_W-1:0] paddr;
    logic                  pwrite;
    logic [AHB_DATA_W-1:0] pwdata;
    logic [3:0]            pstrb;
    logic [2:0]            pprot;
    logic                  psel;
    logic                  penable;
  } apb_mas_send_type;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } apb_bridge_state_e;

endpackage

// File: rtl/ahb_apb_bridge_strb.sv
// Byte-strobe generation plus size/alignment legality for one AHB transfer.
module apb_strb_gen
  import ahb_apb_bridge_pkg::*;
(
  input  logic [2:0] hsize_i,
  input  logic [1:0] addr_i,
  input  logic       hwrite_i,
  output logic [3:0] pstrb_o,
  output logic       size_err_o,
  output logic       align_err_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
    pstrb_o     = 4'b0000;
    size_err_o  = 1'b0;
    align_err_o = 1'b0;
    case (hsize_i)
      HSIZE_BYTE: pstrb_o = 4'b0001 << addr_i;
      HSIZE_HALF: begin
        pstrb_o     = 4'b0011 << addr_i;
        align_err_o = addr_i[0];
      end
      HSIZE_WORD: begin
        pstrb_o     = 4'b1111;
        align_err_o = |addr_i;
      end
      default: size_err_o = 1'b1;
    endcase
    // Reads and illegal transfers never drive byte lanes.
    if (!hwrite_i || size_err_o || align_err_o) pstrb_o = 4'b0000;
  end

endmodule

// File: rtl/ahb_apb_bridge.sv
// Single-slave AHB-Lite to APB4 bridge: one SETUP/ACCESS per accepted transfer, with PREADY timeout.
module ahb_apb_bridge
  import ahb_apb_bridge_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              hclk,
  input  logic              hreset_n,
  input  logic              hsel,
  input  mas_send_type      ahb_in,
  output slv_send_type      ahb_out,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  output logic [3:0]        pstrb,
  output logic [2:0]        pprot,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  apb_bridge_state_e state_q, state_d;
  apb_mas_send_type  apb_q, apb_d;
  logic [2:0]        hsize_q, hsize_d;
  logic [DATA_W-1:0] hrdata_q, hrdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic       hready, accept, req_err, timeout_hit;
  logic       req_size_err, req_align_err;
  logic [3:0] latch_strb;
  logic [3:0] unused_req_strb;
  logic       unused_latch_size_err, unused_latch_align_err;
  logic       unused_ahb;

  // Legality is judged on the live address phase; strobes on the registered one.
  apb_strb_gen u_req_chk (
    .hsize_i     (ahb_in.hsize),
    .addr_i      (ahb_in.haddr[1:0]),
    .hwrite_i    (ahb_in.hwrite),
    .pstrb_o     (unused_req_strb),
    .size_err_o  (req_size_err),
    .align_err_o (req_align_err)
  );

  apb_strb_gen u_latch_strb (
    .hsize_i     (hsize_q),
    .addr_i      (apb_q.paddr[1:0]),
    .hwrite_i    (apb_q.pwrite),
    .pstrb_o     (latch_strb),
    .size_err_o  (unused_latch_size_err),
    .align_err_o (unused_latch_align_err)
  );

  assign unused_ahb  = ^{ahb_in.htrans[0], ahb_in.hburst, ahb_in.hprot[3:2], ahb_in.hmastlock};
  assign hready      = (state_q == ST_IDLE) || (state_q == ST_ERR2);
  assign accept      = hsel && ahb_in.htrans[1] && hready;
  assign req_err     = req_size_err || req_align_err;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d  = state_q;
    apb_d    = apb_q;
    hsize_d  = hsize_q;
    hrdata_d = hrdata_q;
    cnt_d    = '0;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d = ST_IDLE;
        if (accept) begin
          if (req_err) begin
            state_d = ST_ERR1;
          end else begin
            state_d      = ST_LATCH;
            apb_d.paddr  = ahb_in.haddr;
            apb_d.pwrite = ahb_in.hwrite;
            apb_d.pprot  = {~ahb_in.hprot[0], 1'b0, ahb_in.hprot[1]};
            hsize_d      = ahb_in.hsize;
          end
        end
      end
      ST_LATCH: begin
        // hwdata is only valid in the data-phase cycle that follows the accept.
        if (apb_q.pwrite) apb_d.pwdata = ahb_in.hwdata;
        apb_d.pstrb = latch_strb;
        state_d     = ST_SETUP;
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (pready) begin
          if (pslverr) begin
            state_d = ST_ERR1;
          end else begin
            state_d = ST_IDLE;
            if (!apb_q.pwrite) hrdata_d = prdata;
          end
        end else if (timeout_hit) begin
          state_d = ST_ERR1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
    // Select/enable are registered from the next state so they leave the bridge glitch-free.
    apb_d.psel    = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    apb_d.penable = (state_d == ST_ACCESS);
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q  <= ST_IDLE;
      apb_q    <= '0;
      hsize_q  <= '0;
      hrdata_q <= '0;
      cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
      state_q  <= state_d;
      apb_q    <= apb_d;
      hsize_q  <= hsize_d;
      hrdata_q <= hrdata_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ahb_out = '{hreadyout: hready,
                     hrdata:    hrdata_q,
                     hresp:     (state_q == ST_ERR1) || (state_q == ST_ERR2)};
  assign paddr   = apb_q.paddr[ADDR_W-1:0];
  assign psel    = apb_q.psel;
  assign penable = apb_q.penable;
  assign pwrite  = apb_q.pwrite;
  assign pwdata  = apb_q.pwdata;
  assign pstrb   = apb_q.pstrb;
  assign pprot   = apb_q.pprot;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Randomised self-checking bench for ahb_apb_bridge against a transfer-level reference model.
module tb_ahb_apb_bridge;
  import ahb_apb_bridge_pkg::*;

  localparam int TO = 4;

  logic         hclk = 1'b0;
  logic         hreset_n;
  logic         hsel, hsel_nt;
  mas_send_type ahb_in;
  slv_send_type ahb_out, ahb_out_nt;
  logic [31:0]  paddr, pwdata, prdata, paddr_nt, pwdata_nt;
  logic         psel, penable, pwrite, pready, pslverr;
  logic         psel_nt, penable_nt, pwrite_nt;
  logic [3:0]   pstrb, pstrb_nt;
  logic [2:0]   pprot, pprot_nt;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_hrdata = '0;

  always #5 hclk = ~hclk;

  ahb_apb_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel), .ahb_in(ahb_in), .ahb_out(ahb_out),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pstrb(pstrb), .pprot(pprot), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  ahb_apb_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(0)) dut_nt (
    .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel_nt), .ahb_in(ahb_in), .ahb_out(ahb_out_nt),
    .paddr(paddr_nt), .psel(psel_nt), .penable(penable_nt), .pwrite(pwrite_nt), .pwdata(pwdata_nt),
    .pstrb(pstrb_nt), .pprot(pprot_nt), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  task automatic drive_noise();
    ahb_in.haddr     = $urandom;
    ahb_in.hwdata    = $urandom;
    ahb_in.htrans    = 2'($urandom_range(0, 3));
    ahb_in.hburst    = 3'($urandom_range(0, 7));
    ahb_in.hsize     = 3'($urandom_range(0, 7));
    ahb_in.hwrite    = 1'($urandom_range(0, 1));
    ahb_in.hprot     = 4'($urandom_range(0, 15));
    ahb_in.hmastlock = 1'($urandom_range(0, 1));
    hsel             = 1'($urandom_range(0, 1));
    pready           = 1'($urandom_range(0, 1));
    pslverr          = 1'($urandom_range(0, 1));
    prdata           = $urandom;
  endtask

  task automatic drive_quiet();
    drive_noise();
    ahb_in.htrans = ($urandom_range(0, 1) != 0) ? HTRANS_BUSY : HTRANS_IDLE;
  endtask

  // Runs one transfer starting at a negedge where the bridge is ready; returns at the
  // negedge of the first cycle in which hreadyout is high again.
  task automatic run_xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                          input logic [31:0] wdata, input logic [3:0] prot, input int waits,
                          input logic err, input logic [31:0] rdata, input string tag);
    bit          bad, apb_err;
    int          n_acc, last, lo, span;
    logic [3:0]  exp_strb, exp_ctl, obs_ctl;
    logic [39:0] exp_fld, obs_fld;
    bad     = (size > 3'd2) || (size == HSIZE_HALF && addr[0]) ||
              (size == HSIZE_WORD && addr[1:0] != 2'b00);
    apb_err = err || (waits >= TO);
    n_acc   = (waits >= TO) ? TO : waits + 1;
    last    = bad ? 2 : (apb_err ? n_acc + 4 : n_acc + 3);
    lo      = int'(addr[1:0]);
    span    = 1 << int'(size);
    exp_strb = 4'b0000;
    if (wr && !bad)
      for (int b = 0; b < 4; b++) if (b >= lo && b < lo + span) exp_strb[b] = 1'b1;
    exp_fld = {addr, wr, ~prot[0], 1'b0, prot[1], exp_strb};

    n_checks++;
    if (ahb_out.hreadyout !== 1'b1)
      $display("FAIL %s accept_ready: got %b expected 1", tag, ahb_out.hreadyout);
    else n_pass++;
    drive_noise();
    ahb_in.haddr  = addr;
    ahb_in.htrans = ($urandom_range(0, 1) != 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
    ahb_in.hsize  = size;
    ahb_in.hwrite = wr;
    ahb_in.hprot  = prot;
    hsel          = 1'b1;

    for (int c = 1; c <= last; c++) begin
      @(negedge hclk);
      // Expected {hreadyout, hresp, psel, penable} per cycle after the accept.
      if (bad)                exp_ctl = (c == 1) ? 4'b0100 : 4'b1100;
      else if (c == 1)        exp_ctl = 4'b0000;
      else if (c == 2)        exp_ctl = 4'b0010;
      else if (c < n_acc + 3) exp_ctl = 4'b0011;
      else if (c == n_acc + 3) exp_ctl = apb_err ? 4'b0100 : 4'b1000;
      else                    exp_ctl = 4'b1100;
      obs_ctl = {ahb_out.hreadyout, ahb_out.hresp, psel, penable};
      n_checks++;
      if (obs_ctl !== exp_ctl)
        $display("FAIL %s ctl c%0d: got %b expected %b (rdy,resp,psel,pen)", tag, c, obs_ctl, exp_ctl);
      else n_pass++;

      if (!bad && c >= 2 && c < n_acc + 3) begin
        obs_fld = {paddr, pwrite, pprot, pstrb};
        n_checks++;
        if (obs_fld !== exp_fld)
          $display("FAIL %s apb_fields c%0d: got %h expected %h", tag, c, obs_fld, exp_fld);
        else n_pass++;
        if (wr) begin
          n_checks++;
          if (pwdata !== wdata) $display("FAIL %s pwdata c%0d: got %h expected %h", tag, c, pwdata, wdata);
          else n_pass++;
        end
      end

      if (c == last) begin
        if (!bad && !apb_err && !wr) exp_hrdata = rdata;
        n_checks++;
        if (ahb_out.hrdata !== exp_hrdata)
          $display("FAIL %s hrdata: got %h expected %h", tag, ahb_out.hrdata, exp_hrdata);
        else n_pass++;
      end else begin
        drive_noise();
        if (c == 1) ahb_in.hwdata = wdata;
        if (!bad && c >= 3 && c < n_acc + 3) begin
          pready = (c - 3 == waits);
          if (c - 3 == waits) begin
            pslverr = err;
            prdata  = rdata;
          end
        end
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    logic [35:0] obs, exp;
    for (int i = 0; i < n; i++) begin
      drive_quiet();
      @(negedge hclk);
      obs = {ahb_out.hreadyout, ahb_out.hresp, psel, penable, ahb_out.hrdata};
      exp = {4'b1000, exp_hrdata};
      n_checks++;
      if (obs !== exp) $display("FAIL idle_okay: got %h expected %h", obs, exp);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    logic [104:0] obs, exp;
    hreset_n = 1'b0;
    hsel_nt  = 1'b0;
    drive_quiet();
    repeat (3) @(negedge hclk);
    exp = {2'b10, 32'h0, 3'b000, 32'h0, 32'h0, 4'h0};
    obs = {ahb_out.hreadyout, ahb_out.hresp, ahb_out.hrdata, psel, penable, pwrite, paddr, pwdata, pstrb};
    n_checks++;
    if (obs !== exp) $display("FAIL reset_state: got %h expected %h", obs, exp);
    else n_pass++;
    n_checks++;
    if ({ahb_out_nt.hreadyout, psel_nt} !== 2'b10)
      $display("FAIL reset_state_nt: got %b expected 10", {ahb_out_nt.hreadyout, psel_nt});
    else n_pass++;
    hreset_n = 1'b1;
    idle_cycles(4);
  endtask

  task automatic test_directed();
    run_xfer(32'h4000_0010, 1'b0, HSIZE_WORD, $urandom, 4'h3, 0, 1'b0, 32'hDEAD_BEEF, "word_read");
    run_xfer(32'h4000_0003, 1'b1, HSIZE_BYTE, 32'h1122_3344, 4'h0, 3, 1'b0, $urandom, "byte_write");
    run_xfer(32'h4000_0020, 1'b0, HSIZE_WORD, $urandom, 4'h1, 0, 1'b1, 32'h5555_AAAA, "read_slverr");
    idle_cycles(1);
    run_xfer(32'h4000_0002, 1'b1, HSIZE_WORD, $urandom, 4'h2, 0, 1'b0, $urandom, "misaligned_word");
    idle_cycles(1);
    run_xfer(32'h4000_0006, 1'b1, HSIZE_HALF, 32'hCAFE_F00D, 4'h2, 1, 1'b0, $urandom, "half_write_hi");
    run_xfer(32'h4000_0005, 1'b0, HSIZE_HALF, $urandom, 4'h0, 0, 1'b0, $urandom, "misaligned_half");
    run_xfer(32'h4000_0000, 1'b0, 3'd3, $urandom, 4'h0, 0, 1'b0, $urandom, "bad_size");
    idle_cycles(2);
  endtask

  task automatic test_timeout();
    run_xfer(32'h4000_0030, 1'b0, HSIZE_WORD, $urandom, 4'h1, TO + 3, 1'b0, $urandom, "timeout");
    idle_cycles(1);
  endtask

  task automatic test_back_to_back();
    run_xfer(32'h4000_0100, 1'b0, HSIZE_WORD, $urandom, 4'h0, 1, 1'b1, $urandom, "b2b_err");
    run_xfer(32'h4000_0104, 1'b1, HSIZE_WORD, $urandom, 4'h3, 0, 1'b0, $urandom, "b2b_after_err");
    run_xfer(32'h4000_0108, 1'b0, HSIZE_WORD, $urandom, 4'h2, 0, 1'b0, $urandom, "b2b_read");
    run_xfer(32'h4000_0101, 1'b1, HSIZE_BYTE, $urandom, 4'h1, 2, 1'b0, $urandom, "b2b_byte");
    idle_cycles(1);
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic [2:0]  size;
    logic [1:0]  amask;
    for (int i = 0; i < 60; i++) begin
      size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      addr = 32'h4000_0000 | ($urandom & 32'h0000_0FFF);
      amask = (size == HSIZE_BYTE) ? 2'b11 : (size == HSIZE_HALF) ? 2'b10 : 2'b00;
      if ($urandom_range(0, 3) != 0) addr[1:0] = addr[1:0] & amask;
      run_xfer(addr, 1'($urandom_range(0, 1)), size, $urandom, 4'($urandom_range(0, 15)),
               int'($urandom_range(0, TO + 1)), ($urandom_range(0, 4) == 0), $urandom, "rand");
      if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 2)));
    end
    idle_cycles(1);
  endtask

  task automatic test_no_timeout();
    logic [2:0]  obs, exp;
    logic [75:0] obs_f, exp_f;
    drive_quiet();
    ahb_in.haddr  = 32'h4000_0040;
    ahb_in.htrans = HTRANS_NONSEQ;
    ahb_in.hsize  = HSIZE_WORD;
    ahb_in.hwrite = 1'b0;
    ahb_in.hprot  = 4'b0010;
    hsel          = 1'b0;
    hsel_nt       = 1'b1;
    pready        = 1'b0;
    for (int c = 1; c <= 102; c++) begin
      @(negedge hclk);
      exp = (c == 1) ? 3'b000 : (c == 2) ? 3'b010 : 3'b011;
      obs = {ahb_out_nt.hreadyout, psel_nt, penable_nt};
      n_checks++;
      if (obs !== exp) $display("FAIL no_timeout c%0d: got %b expected %b", c, obs, exp);
      else n_pass++;
      drive_quiet();
      hsel_nt = 1'b0;
      pready  = 1'b0;
    end
    obs_f = {paddr_nt, pwrite_nt, pstrb_nt, pprot_nt, pwdata_nt, ahb_out_nt.hresp};
    exp_f = {32'h4000_0040, 1'b0, 4'h0, 3'b101, 32'h0, 1'b0};
    n_checks++;
    if (obs_f !== exp_f) $display("FAIL no_timeout_fields: got %h expected %h", obs_f, exp_f);
    else n_pass++;
    n_checks++;
    if ({ahb_out.hreadyout, ahb_out.hresp, psel} !== 3'b100)
      $display("FAIL no_timeout_main_idle: got %b expected 100", {ahb_out.hreadyout, ahb_out.hresp, psel});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [3:0] obs;
    drive_quiet();
    ahb_in.haddr  = 32'h4000_0080;
    ahb_in.htrans = HTRANS_NONSEQ;
    ahb_in.hsize  = HSIZE_WORD;
    ahb_in.hwrite = 1'b0;
    hsel          = 1'b1;
    pready        = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge hclk);
      drive_quiet();
      hsel   = 1'b0;
      pready = 1'b0;
    end
    n_checks++;
    if ({psel, penable, ahb_out.hreadyout} !== 3'b110)
      $display("FAIL mid_access: got %b expected 110", {psel, penable, ahb_out.hreadyout});
    else n_pass++;
    #2 hreset_n = 1'b0;
    #1;
    exp_hrdata = '0;
    obs = {psel, penable, ahb_out.hreadyout, ahb_out.hresp};
    n_checks++;
    if (obs !== 4'b0010 || ahb_out.hrdata !== exp_hrdata)
      $display("FAIL async_reset: got %b/%h expected 0010/%h", obs, ahb_out.hrdata, exp_hrdata);
    else n_pass++;
    @(negedge hclk);
    hreset_n = 1'b1;
    run_xfer(32'h4000_0084, 1'b0, HSIZE_WORD, $urandom, 4'h0, int'($urandom_range(0, 2)), 1'b0,
             $urandom, "post_reset_read");
    idle_cycles(1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_back_to_back();
    test_random();
    test_no_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
